// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares one combinational, little-endian instruction ROM read port between
//   two requesters. Port 0 is instruction fetch and port 1 is the load/store
//   unit reading constants. Requests are arbitrated round-robin, and each
//   winning address is checked for range and alignment. Each response is then
//   registered in a per-port slot that uses valid/ready backpressure.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req{0,1}_valid  in  request valid
//   req{0,1}_ready  out request accepted this cycle (combinational grant)
//   req{0,1}_addr   in  32-bit byte address
//   rsp{0,1}_valid  out response slot holds a word
//   rsp{0,1}_ready  in  consumer takes the response
//   rsp{0,1}_data   out read word (0 on error)
//   rsp{0,1}_err    out address out of range or misaligned
//   rom_addr        out byte address to the ROM read port
//   rom_rdata       in  combinational ROM data for rom_addr
module rom_port_arbiter #(
  parameter int unsigned SIZE        = 32'd4194304,
  parameter int unsigned ALIGN_CHECK = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // Highest address at which a full word still fits in the ROM. The compare is
  // 33 bits wide so that addresses near 0xFFFFFFFF cannot wrap into range.
  localparam logic [32:0] LAST_WORD = 33'(SIZE) - 33'd4;

  port_e       rr_last_q, rr_last_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic [31:0] rsp0_data_q,  rsp0_data_d;
  logic        rsp0_err_q,   rsp0_err_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp1_data_q,  rsp1_data_d;
  logic        rsp1_err_q,   rsp1_err_d;

  logic        free0, free1;
  logic        elig0, elig1;
  logic        grant0, grant1;
  logic [31:0] win_addr;
  logic        range_err, align_err, win_err;
  logic [31:0] win_data;

  // Arbitration. A slot being drained this cycle counts as free, so a port
  // can stream one response per cycle without a bubble.
  always_comb begin
    free0  = !rsp0_valid_q || rsp0_ready;
    free1  = !rsp1_valid_q || rsp1_ready;
    elig0  = !rst && req0_valid && free0;
    elig1  = !rst && req1_valid && free1;
    grant0 = elig0 && (!elig1 || (rr_last_q == PORT1));
    grant1 = elig1 && (!elig0 || (rr_last_q == PORT0));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The ROM address follows the winner; port 0 drives the ROM when there is
  // no grant, and 0 is driven during reset.
  always_comb begin
    win_addr  = grant1 ? req1_addr : req0_addr;
    rom_addr  = rst ? '0 : win_addr;
    range_err = {1'b0, win_addr} > LAST_WORD;
    align_err = (ALIGN_CHECK != 32'd0) && (win_addr[1:0] != 2'b00);
    win_err   = range_err || align_err;
    win_data  = win_err ? '0 : rom_rdata;
  end

  // Slot and round-robin next state. A grant to a port takes priority over
  // its consume, so a response taken in the same cycle as a new grant to
  // that port is replaced and valid stays high.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_err_d   = rsp1_err_q;
    rr_last_d    = rr_last_q;

    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = win_data;
      rsp0_err_d   = win_err;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = win_data;
      rsp1_err_d   = win_err;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end

    if (grant0) begin
      rr_last_d = PORT0;
    end else if (grant1) begin
      rr_last_d = PORT1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_err_q   <= 1'b0;
      rr_last_q    <= PORT1;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_err_q   <= rsp1_err_d;
      rr_last_q    <= rr_last_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_err   = rsp1_err_q;

  a_one_grant: assert property (@(posedge clk) !(req0_ready && req1_ready));

  a_hold0: assert property (@(posedge clk) disable iff (rst)
    (rsp0_valid && !rsp0_ready) |=> (rsp0_valid && $stable(rsp0_data) && $stable(rsp0_err)));

  a_hold1: assert property (@(posedge clk) disable iff (rst)
    (rsp1_valid && !rsp1_ready) |=> (rsp1_valid && $stable(rsp1_data) && $stable(rsp1_err)));

  // A port that is eligible and loses the arbitration must win on the next
  // cycle if it is still eligible, which bounds the wait to 2 cycles.
  a_fair0: assert property (@(posedge clk) disable iff (rst)
    (elig0 && !grant0) |=> (!elig0 || grant0));

  a_fair1: assert property (@(posedge clk) disable iff (rst)
    (elig1 && !grant1) |=> (!elig1 || grant1));

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

  localparam int unsigned SIZE = 32'd4194304;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic        rsp_ready [2];

  // [dut][port]; dut 0 has alignment checking, dut 1 does not
  logic        qr [2][2];
  logic        rv [2][2];
  logic [31:0] rd [2][2];
  logic        re [2][2];
  logic [31:0] ra  [2];
  logic [31:0] rrd [2];

  int check_cnt = 0;
  int pass_cnt  = 0;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'hA5A51234;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input bit align);
    longint unsigned la;
    la = 64'(a);
    return (la + 4 > 64'(SIZE)) || (align && (a % 4 != 0));
  endfunction

  assign rrd[0] = rom_fn(ra[0]);
  assign rrd[1] = rom_fn(ra[1]);

  rom_port_arbiter #(.SIZE(SIZE), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(qr[0][0]), .req0_addr(req_addr[0]),
    .rsp0_valid(rv[0][0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rd[0][0]), .rsp0_err(re[0][0]),
    .req1_valid(req_valid[1]), .req1_ready(qr[0][1]), .req1_addr(req_addr[1]),
    .rsp1_valid(rv[0][1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rd[0][1]), .rsp1_err(re[0][1]),
    .rom_addr(ra[0]), .rom_rdata(rrd[0])
  );

  rom_port_arbiter #(.SIZE(SIZE), .ALIGN_CHECK(0)) dut_na (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(qr[1][0]), .req0_addr(req_addr[0]),
    .rsp0_valid(rv[1][0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rd[1][0]), .rsp0_err(re[1][0]),
    .req1_valid(req_valid[1]), .req1_ready(qr[1][1]), .req1_addr(req_addr[1]),
    .rsp1_valid(rv[1][1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rd[1][1]), .rsp1_err(re[1][1]),
    .rom_addr(ra[1]), .rom_rdata(rrd[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level reference: one slot per port, a record of the last winner.
  logic        m_valid [2];
  logic [31:0] m_data  [2][2];
  logic        m_err   [2][2];
  int          m_last;
  logic        m_elig  [2];
  int          m_win;
  logic [31:0] m_addr;
  logic        m_xerr  [2];
  logic [31:0] m_xdata [2];

  always_comb begin
    for (int p = 0; p < 2; p++)
      m_elig[p] = !rst && req_valid[p] && (!m_valid[p] || rsp_ready[p]);
    if (m_elig[0] && m_elig[1]) m_win = 1 - m_last;
    else if (m_elig[0])         m_win = 0;
    else if (m_elig[1])         m_win = 1;
    else                        m_win = -1;
    m_addr = rst ? 32'h0 : ((m_win == 1) ? req_addr[1] : req_addr[0]);
    for (int d = 0; d < 2; d++) begin
      m_xerr[d]  = exp_err(m_addr, d == 0);
      m_xdata[d] = m_xerr[d] ? 32'h0 : rom_fn(m_addr);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_valid[p] <= 1'b0;
        for (int d = 0; d < 2; d++) begin
          m_data[d][p] <= 32'h0;
          m_err[d][p]  <= 1'b0;
        end
      end
      m_last <= 1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (m_win == p) begin
          m_valid[p] <= 1'b1;
          for (int d = 0; d < 2; d++) begin
            m_data[d][p] <= m_xdata[d];
            m_err[d][p]  <= m_xerr[d];
          end
        end else if (rsp_ready[p]) begin
          m_valid[p] <= 1'b0;
        end
      end
      if (m_win >= 0) m_last <= m_win;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0;
      req_addr[p]  = 32'h0;
      rsp_ready[p] = 1'b1;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    req_addr[0] = 32'h20; req_addr[1] = 32'h24;
    for (int c = 0; c < 2; c++) begin
      #4;
      check_cnt++;
      if (qr[0][0] !== 1'b0 || qr[0][1] !== 1'b0)
        $display("FAIL reset_req_ready: got %b%b expected 00", qr[0][0], qr[0][1]);
      else pass_cnt++;
      check_cnt++;
      if (ra[0] !== 32'h0) $display("FAIL reset_rom_addr: got %h expected 0", ra[0]);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (rv[0][0] !== 1'b0 || rv[0][1] !== 1'b0 || rd[0][0] !== 32'h0 || rd[0][1] !== 32'h0 ||
          re[0][0] !== 1'b0 || re[0][1] !== 1'b0)
        $display("FAIL reset_rsp: got v=%b%b d=%h/%h e=%b%b expected all 0",
                 rv[0][0], rv[0][1], rd[0][0], rd[0][1], re[0][0], re[0][1]);
      else pass_cnt++;
    end
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      #4;
      check_cnt++;
      if (qr[0][0] !== 1'b0 || qr[0][1] !== 1'b0)
        $display("FAIL idle_req_ready: got %b%b expected 00", qr[0][0], qr[0][1]);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (rv[0][0] !== 1'b0 || rv[0][1] !== 1'b0 || rd[0][0] !== 32'h0)
        $display("FAIL idle_rsp: got v=%b%b d=%h expected 0", rv[0][0], rv[0][1], rd[0][0]);
      else pass_cnt++;
    end
    // First contention after reset goes to port 0.
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    req_addr[0] = 32'h20; req_addr[1] = 32'h24;
    #4;
    check_cnt++;
    if (qr[0][0] !== 1'b1 || qr[0][1] !== 1'b0)
      $display("FAIL reset_first_winner: got %b%b expected 10", qr[0][0], qr[0][1]);
    else pass_cnt++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_single_fetch();
    do_reset();
    req_valid[0] = 1'b1; req_addr[0] = 32'h10;
    #4;
    check_cnt++;
    if (qr[0][0] !== 1'b1 || ra[0] !== 32'h10)
      $display("FAIL fetch_grant: got ready=%b addr=%h expected 1/00000010", qr[0][0], ra[0]);
    else pass_cnt++;
    tick();
    req_valid[0] = 1'b0;
    check_cnt++;
    if (rv[0][0] !== 1'b1 || rd[0][0] !== 32'hDEADBEEF || re[0][0] !== 1'b0)
      $display("FAIL fetch_rsp: got v=%b d=%h e=%b expected 1/deadbeef/0", rv[0][0], rd[0][0], re[0][0]);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (rv[0][0] !== 1'b0) $display("FAIL fetch_clear: got %b expected 0", rv[0][0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1; req_addr[0] = addrs[i];
      #4;
      check_cnt++;
      if (qr[0][0] !== 1'b1) $display("FAIL b2b_grant%0d: got %b expected 1", i, qr[0][0]);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (rv[0][0] !== 1'b1 || rd[0][0] !== rom_fn(addrs[i]))
        $display("FAIL b2b_rsp%0d: got v=%b d=%h expected 1/%h", i, rv[0][0], rd[0][0], rom_fn(addrs[i]));
      else pass_cnt++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    int cnt [2];
    cnt[0] = 0; cnt[1] = 0;
    do_reset();
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    req_addr[0] = 32'h40; req_addr[1] = 32'h80;
    for (int c = 0; c < 4; c++) begin
      #4;
      check_cnt++;
      if (qr[0][c % 2] !== 1'b1 || qr[0][1 - (c % 2)] !== 1'b0)
        $display("FAIL contend_grant%0d: got %b%b expected port %0d", c, qr[0][0], qr[0][1], c % 2);
      else pass_cnt++;
      tick();
      for (int p = 0; p < 2; p++) if (rv[0][p] === 1'b1) cnt[p]++;
    end
    idle_inputs();
    check_cnt++;
    if (cnt[0] != 2 || cnt[1] != 2)
      $display("FAIL contend_count: got %0d/%0d expected 2/2", cnt[0], cnt[1]);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1; req_addr[1] = 32'h100;
    #4;
    check_cnt++;
    if (qr[0][1] !== 1'b1) $display("FAIL bp_first_grant: got %b expected 1", qr[0][1]);
    else pass_cnt++;
    tick();
    held = rd[0][1];
    check_cnt++;
    if (held !== rom_fn(32'h100)) $display("FAIL bp_first_rsp: got %h expected %h", held, rom_fn(32'h100));
    else pass_cnt++;
    req_addr[1] = 32'h300;
    for (int c = 0; c < 3; c++) begin
      req_valid[0] = 1'b1; req_addr[0] = 32'h200 + 32'(4 * c);
      #4;
      check_cnt++;
      if (qr[0][1] !== 1'b0 || qr[0][0] !== 1'b1)
        $display("FAIL bp_hold_grant%0d: got %b%b expected 10", c, qr[0][0], qr[0][1]);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (rv[0][1] !== 1'b1 || rd[0][1] !== rom_fn(32'h100) || re[0][1] !== 1'b0)
        $display("FAIL bp_hold_rsp%0d: got v=%b d=%h e=%b expected 1/%h/0", c, rv[0][1], rd[0][1], re[0][1], rom_fn(32'h100));
      else pass_cnt++;
      check_cnt++;
      if (rd[0][0] !== rom_fn(32'h200 + 32'(4 * c)))
        $display("FAIL bp_port0_rsp%0d: got %h expected %h", c, rd[0][0], rom_fn(32'h200 + 32'(4 * c)));
      else pass_cnt++;
    end
    rsp_ready[1] = 1'b1;
    #4;
    check_cnt++;
    if (qr[0][1] !== 1'b1 || qr[0][0] !== 1'b0)
      $display("FAIL bp_release_grant: got %b%b expected 01", qr[0][0], qr[0][1]);
    else pass_cnt++;
    tick();
    idle_inputs();
    check_cnt++;
    if (rv[0][1] !== 1'b1 || rd[0][1] !== rom_fn(32'h300))
      $display("FAIL bp_release_rsp: got v=%b d=%h expected 1/%h", rv[0][1], rd[0][1], rom_fn(32'h300));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] a [4];
    logic        e_al [4];
    logic        e_na [4];
    a[0] = SIZE - 4;       e_al[0] = 1'b0; e_na[0] = 1'b0;
    a[1] = SIZE - 3;       e_al[1] = 1'b1; e_na[1] = 1'b1;
    a[2] = 32'hFFFFFFFC;   e_al[2] = 1'b1; e_na[2] = 1'b1;
    a[3] = 32'h2;          e_al[3] = 1'b1; e_na[3] = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = 1'b1; req_addr[0] = a[i];
      tick();
      check_cnt++;
      if (re[0][0] !== e_al[i] || rd[0][0] !== (e_al[i] ? 32'h0 : rom_fn(a[i])))
        $display("FAIL err_align_%h: got e=%b d=%h expected e=%b", a[i], re[0][0], rd[0][0], e_al[i]);
      else pass_cnt++;
      check_cnt++;
      if (re[1][0] !== e_na[i] || rd[1][0] !== (e_na[i] ? 32'h0 : rom_fn(a[i])))
        $display("FAIL err_noalign_%h: got e=%b d=%h expected e=%b", a[i], re[1][0], rd[1][0], e_na[i]);
      else pass_cnt++;
    end
    // Reset while a response is being held.
    rsp_ready[0] = 1'b0; req_addr[0] = 32'h8;
    tick();
    #4;
    check_cnt++;
    if (qr[0][0] !== 1'b0 || rv[0][0] !== 1'b1)
      $display("FAIL rst_hold_pre: got ready=%b valid=%b expected 0/1", qr[0][0], rv[0][0]);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    check_cnt++;
    if (rv[0][0] !== 1'b0 || rv[1][0] !== 1'b0)
      $display("FAIL rst_hold_clear: got %b%b expected 00", rv[0][0], rv[1][0]);
    else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3, 4: return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      5:             return 32'($urandom_range(0, 4095));
      6:             return SIZE - 32'($urandom_range(0, 8));
      default:       return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < 2; p++) begin
        req_valid[p] = ($urandom_range(0, 3) != 0);
        req_addr[p]  = rand_addr();
        rsp_ready[p] = ($urandom_range(0, 2) != 0);
      end
      #4;
      for (int d = 0; d < 2; d++) begin
        check_cnt++;
        if (qr[d][0] !== (m_win == 0) || qr[d][1] !== (m_win == 1) || ra[d] !== m_addr)
          $display("FAIL rand_grant c%0d d%0d: got rdy=%b%b addr=%h expected win=%0d addr=%h",
                   c, d, qr[d][0], qr[d][1], ra[d], m_win, m_addr);
        else pass_cnt++;
        for (int p = 0; p < 2; p++) begin
          check_cnt++;
          if (rv[d][p] !== m_valid[p] || rd[d][p] !== m_data[d][p] || re[d][p] !== m_err[d][p])
            $display("FAIL rand_rsp c%0d d%0d p%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                     c, d, p, rv[d][p], rd[d][p], re[d][p], m_valid[p], m_data[d][p], m_err[d][p]);
          else pass_cnt++;
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    tick();
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_contention();
    test_backpressure();
    test_errors();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
